// File: rtl/morse_keyer.sv
// Morse keyer: accepts one ASCII character per valid/ready handshake and keys
// its ITU Morse code on a single output with unit-based dot, dash and gap timing.
module morse_keyer #(
    parameter int unsigned CLKS_PER_UNIT    = 2_500_000,
    parameter int unsigned DASH_UNITS       = 3,
    parameter int unsigned LETTER_GAP_UNITS = 3,
    parameter int unsigned WORD_GAP_UNITS   = 7
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [7:0] i_Char,
    input  logic       i_Char_Valid,
    output logic       o_Char_Ready,
    input  logic       i_Abort,
    output logic       o_Key,
    output logic       o_Invalid
);
    localparam int unsigned DOT_CLKS    = CLKS_PER_UNIT;
    localparam int unsigned DASH_CLKS   = DASH_UNITS * CLKS_PER_UNIT;
    localparam int unsigned LETTER_CLKS = LETTER_GAP_UNITS * CLKS_PER_UNIT;
    localparam int unsigned WORD_CLKS   = (WORD_GAP_UNITS - LETTER_GAP_UNITS) * CLKS_PER_UNIT;
    localparam int unsigned MAX_A       = (DASH_CLKS > LETTER_CLKS) ? DASH_CLKS : LETTER_CLKS;
    localparam int unsigned MAX_CLKS    = (MAX_A > WORD_CLKS) ? MAX_A : WORD_CLKS;
    localparam int unsigned CNT_W       = $clog2(MAX_CLKS) + 1;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        ELEM_GAP,
        LETTER_GAP,
        WORD_GAP
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [4:0]       pattern, pattern_d;
    logic [2:0]       len, len_d;
    logic [2:0]       idx, idx_d;
    logic             key_d, invalid_d;
    logic [7:0]       ch_fold;
    logic [4:0]       lut_pat;
    logic [2:0]       lut_len;

    // Pattern is left-aligned (first element at bit 4), 1 = dash; length 0 = unsupported.
    function automatic logic [7:0] morse_lut(input logic [7:0] ch);
        case (ch)
            "a": return {5'b01000, 3'd2};
            "b": return {5'b10000, 3'd4};
            "c": return {5'b10100, 3'd4};
            "d": return {5'b10000, 3'd3};
            "e": return {5'b00000, 3'd1};
            "f": return {5'b00100, 3'd4};
            "g": return {5'b11000, 3'd3};
            "h": return {5'b00000, 3'd4};
            "i": return {5'b00000, 3'd2};
            "j": return {5'b01110, 3'd4};
            "k": return {5'b10100, 3'd3};
            "l": return {5'b01000, 3'd4};
            "m": return {5'b11000, 3'd2};
            "n": return {5'b10000, 3'd2};
            "o": return {5'b11100, 3'd3};
            "p": return {5'b01100, 3'd4};
            "q": return {5'b11010, 3'd4};
            "r": return {5'b01000, 3'd3};
            "s": return {5'b00000, 3'd3};
            "t": return {5'b10000, 3'd1};
            "u": return {5'b00100, 3'd3};
            "v": return {5'b00010, 3'd4};
            "w": return {5'b01100, 3'd3};
            "x": return {5'b10010, 3'd4};
            "y": return {5'b10110, 3'd4};
            "z": return {5'b11000, 3'd4};
            "0": return {5'b11111, 3'd5};
            "1": return {5'b01111, 3'd5};
            "2": return {5'b00111, 3'd5};
            "3": return {5'b00011, 3'd5};
            "4": return {5'b00001, 3'd5};
            "5": return {5'b00000, 3'd5};
            "6": return {5'b10000, 3'd5};
            "7": return {5'b11000, 3'd5};
            "8": return {5'b11100, 3'd5};
            "9": return {5'b11110, 3'd5};
            default: return 8'h00;
        endcase
    endfunction

    // Case-fold upper-case letters before lookup.
    always_comb begin
        ch_fold = i_Char;
        if (i_Char >= 8'h41 && i_Char <= 8'h5A) begin
            ch_fold = i_Char | 8'h20;
        end
        {lut_pat, lut_len} = morse_lut(ch_fold);
    end

    assign o_Char_Ready = (state == IDLE);

    // Next-state and registered-output logic; key_d mirrors entry into MARK.
    always_comb begin
        state_d   = state;
        cnt_d     = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        pattern_d = pattern;
        len_d     = len;
        idx_d     = idx;
        key_d     = 1'b0;
        invalid_d = 1'b0;

        case (state)
            IDLE: begin
                if (i_Char_Valid) begin
                    if (i_Char == 8'h20) begin
                        state_d = WORD_GAP;
                        cnt_d   = CNT_W'(WORD_CLKS - 1);
                    end else if (lut_len != 3'd0) begin
                        state_d   = MARK;
                        pattern_d = lut_pat;
                        len_d     = lut_len;
                        idx_d     = 3'd0;
                        cnt_d     = lut_pat[4] ? CNT_W'(DASH_CLKS - 1) : CNT_W'(DOT_CLKS - 1);
                        key_d     = 1'b1;
                    end else begin
                        invalid_d = 1'b1;
                    end
                end
            end
            MARK: begin
                key_d = 1'b1;
                if (cnt == '0) begin
                    key_d = 1'b0;
                    if (idx + 3'd1 < len) begin
                        state_d = ELEM_GAP;
                        cnt_d   = CNT_W'(DOT_CLKS - 1);
                    end else begin
                        state_d = LETTER_GAP;
                        cnt_d   = CNT_W'(LETTER_CLKS - 1);
                    end
                end
            end
            ELEM_GAP: begin
                if (cnt == '0) begin
                    state_d   = MARK;
                    idx_d     = idx + 3'd1;
                    pattern_d = {pattern[3:0], 1'b0};
                    cnt_d     = pattern[3] ? CNT_W'(DASH_CLKS - 1) : CNT_W'(DOT_CLKS - 1);
                    key_d     = 1'b1;
                end
            end
            LETTER_GAP, WORD_GAP: begin
                if (cnt == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Abort drops the character immediately, without a letter gap.
        if (state != IDLE && i_Abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            key_d   = 1'b0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state     <= IDLE;
            cnt       <= '0;
            pattern   <= '0;
            len       <= '0;
            idx       <= '0;
            o_Key     <= 1'b0;
            o_Invalid <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            pattern   <= pattern_d;
            len       <= len_d;
            idx       <= idx_d;
            o_Key     <= key_d;
            o_Invalid <= invalid_d;
        end
    end
endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: randomized characters against a dot/dash string model,
// with a queue-based scoreboard checking the keyed waveform of each accepted character.
module tb_morse_keyer;
    localparam int unsigned U    = 4;
    localparam int unsigned DASH = 3;
    localparam int unsigned LG   = 3;
    localparam int unsigned WG   = 7;

    logic       i_Clk;
    logic       i_Rst_L;
    logic [7:0] i_Char;
    logic       i_Char_Valid;
    logic       o_Char_Ready;
    logic       i_Abort;
    logic       o_Key;
    logic       o_Invalid;

    morse_keyer #(
        .CLKS_PER_UNIT(U),
        .DASH_UNITS(DASH),
        .LETTER_GAP_UNITS(LG),
        .WORD_GAP_UNITS(WG)
    ) dut (
        .i_Clk(i_Clk),
        .i_Rst_L(i_Rst_L),
        .i_Char(i_Char),
        .i_Char_Valid(i_Char_Valid),
        .o_Char_Ready(o_Char_Ready),
        .i_Abort(i_Abort),
        .o_Key(o_Key),
        .o_Invalid(o_Invalid)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [127:0] wave;
        int           busy;
        bit           inv;
        logic [7:0]   ch;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic string morse_of(input logic [7:0] c);
        logic [7:0] l;
        l = (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
        case (l)
            "a": return ".-";    "b": return "-...";  "c": return "-.-.";
            "d": return "-..";   "e": return ".";     "f": return "..-.";
            "g": return "--.";   "h": return "....";  "i": return "..";
            "j": return ".---";  "k": return "-.-";   "l": return ".-..";
            "m": return "--";    "n": return "-.";    "o": return "---";
            "p": return ".--.";  "q": return "--.-";  "r": return ".-.";
            "s": return "...";   "t": return "-";     "u": return "..-";
            "v": return "...-";  "w": return ".--";   "x": return "-..-";
            "y": return "-.--";  "z": return "--..";
            "0": return "-----"; "1": return ".----"; "2": return "..---";
            "3": return "...--"; "4": return "....-"; "5": return ".....";
            "6": return "-...."; "7": return "--..."; "8": return "---..";
            "9": return "----.";
            default: return "";
        endcase
    endfunction

    // Expected key level for cycles 1..busy after the accept edge.
    function automatic void build(input logic [7:0] c, output logic [127:0] w,
                                  output int busy, output bit inv);
        string m;
        int    p;
        w = '0; busy = 0; inv = 1'b0; p = 0;
        if (c == 8'h20) begin
            busy = int'((WG - LG) * U);
            return;
        end
        m = morse_of(c);
        if (m.len() == 0) begin
            inv = 1'b1;
            return;
        end
        for (int i = 0; i < m.len(); i++) begin
            int n;
            n = (m[i] == 8'h2D) ? int'(DASH * U) : int'(U);
            for (int j = 0; j < n; j++) begin
                w[p] = 1'b1;
                p++;
            end
            if (i < m.len() - 1) p += int'(U);
        end
        busy = p + int'(LG * U);
    endfunction

    // Monitor: pops one expectation per observed accept and checks the busy window.
    txn_t         cur;
    bit           mon_active = 1'b0;
    int           cyc;
    logic [127:0] act_wave;
    int           ready_bad;
    int           inv_bad;

    always @(negedge i_Clk) begin
        if (!i_Rst_L) begin
            mon_active = 1'b0;
        end else begin
            if (mon_active) begin
                cyc++;
                if (cyc <= cur.busy) begin
                    act_wave[cyc-1] = o_Key;
                    if (o_Char_Ready) ready_bad++;
                    if (o_Invalid) inv_bad++;
                end else begin
                    checks++;
                    if (act_wave !== cur.wave) begin
                        errors++;
                        $display("FAIL wave ch=%h got=%h exp=%h", cur.ch, act_wave, cur.wave);
                    end
                    checks++;
                    if (ready_bad != 0 || o_Char_Ready !== 1'b1) begin
                        errors++;
                        $display("FAIL ready ch=%h busy_ready_cycles=%0d ready_at_return=%b exp 0 and 1",
                                 cur.ch, ready_bad, o_Char_Ready);
                    end
                    checks++;
                    if (inv_bad != 0 || o_Invalid !== cur.inv) begin
                        errors++;
                        $display("FAIL invalid ch=%h busy_pulses=%0d got=%b exp=%b",
                                 cur.ch, inv_bad, o_Invalid, cur.inv);
                    end
                    checks++;
                    if (o_Key !== 1'b0) begin
                        errors++;
                        $display("FAIL key_return ch=%h got=%b exp=0", cur.ch, o_Key);
                    end
                    mon_active = 1'b0;
                end
            end else begin
                checks++;
                if (o_Key !== 1'b0 || o_Invalid !== 1'b0 || o_Char_Ready !== 1'b1) begin
                    errors++;
                    $display("FAIL idle key=%b inv=%b ready=%b exp 0 0 1", o_Key, o_Invalid, o_Char_Ready);
                end
            end
            if (!mon_active && i_Char_Valid && o_Char_Ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL accept unexpected ch=%h exp none", i_Char);
                end else begin
                    cur        = exp_q.pop_front();
                    mon_active = 1'b1;
                    cyc        = 0;
                    act_wave   = '0;
                    ready_bad  = 0;
                    inv_bad    = 0;
                end
            end
        end
    end

    // Offer one character; abort_req > 0 requests an abort in a cycle of the busy window.
    task automatic send(input logic [7:0] c, input int abort_req, input bit hold_abort);
        txn_t t;
        int   guard;
        int   k;
        build(c, t.wave, t.busy, t.inv);
        t.ch = c;
        k = 0;
        if (abort_req > 0 && t.busy > 0) begin
            k = ((abort_req - 1) % t.busy) + 1;
            t.busy = k;
            for (int i = k; i < 128; i++) t.wave[i] = 1'b0;
        end
        i_Char       = c;
        i_Char_Valid = 1'b1;
        guard        = 0;
        while (o_Char_Ready !== 1'b1 && guard < 200) begin
            @(posedge i_Clk);
            #1;
            guard++;
        end
        if (o_Char_Ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_wait ch=%h ready=%b exp 1 within 200 cycles", c, o_Char_Ready);
            i_Char_Valid = 1'b0;
            return;
        end
        i_Abort = hold_abort;
        exp_q.push_back(t);
        @(posedge i_Clk);
        #1;
        i_Abort      = 1'b0;
        i_Char_Valid = 1'b0;
        i_Char       = 8'($urandom);
        if (k > 0) begin
            repeat (k - 1) @(posedge i_Clk);
            #1;
            i_Abort = 1'b1;
            @(posedge i_Clk);
            #1;
            i_Abort = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] c;
        int         guard;
        i_Rst_L      = 1'b0;
        i_Char       = 8'h00;
        i_Char_Valid = 1'b0;
        i_Abort      = 1'b0;
        repeat (2) @(posedge i_Clk);
        #1;
        checks++;
        if (o_Key !== 1'b0) begin errors++; $display("FAIL reset_key got=%b exp=0", o_Key); end
        checks++;
        if (o_Char_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_Char_Ready); end
        checks++;
        if (o_Invalid !== 1'b0) begin errors++; $display("FAIL reset_invalid got=%b exp=0", o_Invalid); end
        i_Rst_L = 1'b1;
        @(posedge i_Clk);
        #1;

        send("E", 0, 1'b0);
        send("a", 0, 1'b0);
        send("0", 0, 1'b0);
        send("T", 0, 1'b0);
        send("e", 0, 1'b0);
        send(" ", 0, 1'b0);
        send("e", 0, 1'b0);
        send("#", 0, 1'b0);
        send("e", 0, 1'b0);
        send("0", 10, 1'b0);
        send("k", 0, 1'b1);

        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: c = 8'(8'h61 + $urandom_range(0, 25));
                4, 5:       c = 8'(8'h41 + $urandom_range(0, 25));
                6, 7:       c = 8'(8'h30 + $urandom_range(0, 9));
                8:          c = 8'h20;
                default:    c = 8'($urandom);
            endcase
            repeat ($urandom_range(0, 3)) @(posedge i_Clk);
            #1;
            send(c, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 200)) : 0,
                 ($urandom_range(0, 5) == 0));
        end

        // Reset in the middle of a dash.
        send("t", 0, 1'b0);
        repeat (5) @(posedge i_Clk);
        #1;
        i_Rst_L = 1'b0;
        @(posedge i_Clk);
        #1;
        checks++;
        if (o_Key !== 1'b0) begin errors++; $display("FAIL midreset_key got=%b exp=0", o_Key); end
        checks++;
        if (o_Char_Ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%b exp=1", o_Char_Ready); end
        i_Rst_L = 1'b1;
        send("e", 0, 1'b0);

        guard = 0;
        while ((mon_active || exp_q.size() != 0) && guard < 500) begin
            @(posedge i_Clk);
            guard++;
        end
        checks++;
        if (mon_active || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d active=%b exp 0 0", exp_q.size(), mon_active);
        end
        repeat (3) @(posedge i_Clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/morse_keyer.md
# morse_keyer

Sequential Morse transmitter: accepts one ASCII character per valid/ready handshake, looks up its ITU Morse code, and drives a single key/LED output with dot, dash and gap timing derived from a parametrised unit length. It sits between the character source (UART receive or message ROM) and the board LED. It is the timed, handshaked next generation of the combinational character-to-pattern lookup, and adds word spacing, invalid-character reporting and abort.

## Interface
- CLKS_PER_UNIT, 2_500_000: clock cycles per Morse unit (dot length); must be ≥1.
- DASH_UNITS, 3: dash length in units; must be ≥1.
- LETTER_GAP_UNITS, 3: key-off time after the last element of a character; must be ≥1.
- WORD_GAP_UNITS, 7: total key-off time between words; must be > LETTER_GAP_UNITS.
- i_Clk  in  1  system clock; all logic on rising edge.
- i_Rst_L  in  1  synchronous, active-low reset.
- i_Char  in  8  ASCII character.
- i_Char_Valid  in  1  i_Char is valid.
- o_Char_Ready  out  1  block can accept a character.
- i_Abort  in  1  abandon the current character.
- o_Key  out  1  Morse key output; 1 = mark (LED on).
- o_Invalid  out  1  one-cycle pulse when an unsupported character is dropped.

## Operation
- **Accept:** a character is accepted at a rising edge where i_Char_Valid & o_Char_Ready. o_Char_Ready = (state == IDLE), decoded from the state register.
- **Case folding:** 'A'–'Z' (0x41–0x5A) fold to 'a'–'z'.
- **Lookup:** an internal table holds a 5-bit pattern and a 3-bit length. The first element is at bit 4. 1 = dash, 0 = dot. Coverage is 'a'–'z' and '0'–'9' (ITU). Examples: 'a' = dot-dash, length 2; '0' = 5 dashes.
- **States:** IDLE, MARK, ELEM_GAP, LETTER_GAP, WORD_GAP.
- **IDLE:**
  - Valid letter or digit → MARK with the first element; element index = 0.
  - 0x20 (space) → WORD_GAP.
  - Any other code → stays IDLE and pulses o_Invalid.
- **MARK:** o_Key = 1 for CLKS_PER_UNIT cycles (dot) or DASH_UNITS*CLKS_PER_UNIT cycles (dash). At the end:
  - More elements remain → ELEM_GAP.
  - Otherwise → LETTER_GAP.
- **ELEM_GAP:** o_Key = 0 for CLKS_PER_UNIT cycles, then MARK with the next element (index+1).
- **LETTER_GAP:** o_Key = 0 for LETTER_GAP_UNITS*CLKS_PER_UNIT cycles, then IDLE.
- **WORD_GAP:** o_Key = 0 for (WORD_GAP_UNITS − LETTER_GAP_UNITS)*CLKS_PER_UNIT cycles, then IDLE. This makes letter + space = WORD_GAP_UNITS.
- **Latching:** pattern and length are captured at accept. i_Char may change afterwards without effect.
- **Cycle counter:** a single down-counter, width $clog2 of the largest timed interval + 1. It is loaded with (duration − 1) on each state entry and advances the state at 0. No wrap-around beyond the load value.
- **Abort:** i_Abort high in any non-IDLE state → next state IDLE, o_Key = 0, no letter gap. In IDLE, i_Abort is ignored and acceptance proceeds normally. An accept and an abort in the same cycle cannot conflict, since accept happens only in IDLE.
- **Back-to-back characters:** because the letter gap is always inserted, consecutive characters are correctly spaced with no external delay.

## Timing
- **Reset:** i_Rst_L = 0 at an edge → state IDLE, counter 0. After that edge: o_Key = 0, o_Char_Ready = 1, o_Invalid = 0.
  - Reset mid-character discards it entirely.
  - Reset has priority over abort and accept.
- **Output registering:** o_Key and o_Invalid are registered.
- **Cycle numbering:** accept at edge 0. The first mark or invalid pulse is visible in cycle 1 (after edge 1? no — the output is updated at edge 0).
  - Concretely: o_Key is high starting the cycle after the accept edge.
  - o_Invalid is high for exactly that one cycle.
- **Invalid character:** o_Char_Ready stays 1 throughout, so a new character can be accepted at the very next edge.
- **Total busy time per character:** sum(element units) + (len − 1) + LETTER_GAP_UNITS, times CLKS_PER_UNIT.
- **Ready return:** o_Char_Ready returns to 1 in the cycle after the final gap cycle.

## Test plan
All scenarios use CLKS_PER_UNIT = 4 and defaults otherwise. "Cycle n" means n cycles after the accept edge.
- **'E' (0x45):** o_Key = 1 in cycles 1–4, 0 in cycles 5–16; o_Char_Ready = 1 from cycle 17.
- **'a':** o_Key = 1 in 1–4, 0 in 5–8, 1 in 9–20, 0 in 21–32; ready at cycle 33.
- **'0', then 'T' presented back-to-back with valid held:**
  - '0': five 12-cycle marks separated by 4-cycle gaps.
  - 'T' is accepted at the first edge where ready = 1, after 12 gap cycles.
  - 'T' then produces a 12-cycle mark.
- **Space (0x20) after 'e':** o_Key stays 0 for 16 cycles after the letter gap. The measured off-time between the end of the 'e' mark and the next mark is 28 cycles (7 units).
- **'#' (0x23):** o_Invalid = 1 for exactly one cycle, o_Key stays 0, ready never drops. A following 'e' on the next edge is keyed normally.
- **Abort and reset:**
  - i_Abort asserted in cycle 10 of '0' → o_Key = 0 and ready = 1 from cycle 11.
  - i_Rst_L = 0 in the middle of a dash → o_Key = 0 and ready = 1 after that edge.
